mem_stage: RTL

Memory-access stage sitting between EX/MEM and the writeback stage. It issues word-aligned data-memory requests over a req/ack handshake, generates store byte strobes, and extracts and sign/zero-extends load data. It stalls upstream while a request is outstanding and presents a registered result (rd_addr, rd_value, load_data, instr_id) to writeback. Misaligned accesses and bus timeouts are flagged instead of being issued.

---
 rtl/mem_stage_pkg.sv | 42 ++++
 rtl/mem_align.sv | 67 ++++++
 rtl/mem_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared instruction ids, FSM state encodings and memory-op classification
// helpers for the memory-access stage.
package mem_stage_pkg;

   localparam logic [5:0] INSTR_NOP = 6'd0;
   localparam logic [5:0] INSTR_ADD = 6'd1;
   localparam logic [5:0] INSTR_SUB = 6'd2;
   localparam logic [5:0] INSTR_AND = 6'd3;
   localparam logic [5:0] INSTR_OR  = 6'd4;
   localparam logic [5:0] INSTR_LB  = 6'd10;
   localparam logic [5:0] INSTR_LH  = 6'd11;
   localparam logic [5:0] INSTR_LW  = 6'd12;
   localparam logic [5:0] INSTR_LBU = 6'd13;
   localparam logic [5:0] INSTR_LHU = 6'd14;
   localparam logic [5:0] INSTR_SB  = 6'd15;
   localparam logic [5:0] INSTR_SH  = 6'd16;
   localparam logic [5:0] INSTR_SW  = 6'd17;

   typedef enum logic [0:0] {
      MEM_IDLE = 1'b0,
      MEM_BUSY = 1'b1
   } mem_state_e;

   function automatic logic is_load(input logic [5:0] id);
      case (id)
         INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU: return 1'b1;
         default:                                            return 1'b0;
      endcase
   endfunction

   function automatic logic is_store(input logic [5:0] id);
      case (id)
         INSTR_SB, INSTR_SH, INSTR_SW: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

   function automatic logic is_mem(input logic [5:0] id);
      return is_load(id) | is_store(id);
   endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store strobes/data replication, load
// extraction with sign/zero extension, and alignment fault detection.
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [5:0]  instr_id,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rs2,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        misaligned
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (addr_lo)
         2'd0:    w_byte = rdata[7:0];
         2'd1:    w_byte = rdata[15:8];
         2'd2:    w_byte = rdata[23:16];
         default: w_byte = rdata[31:24];
      endcase
      w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      wstrb      = 4'b0000;
      wdata      = 32'h0;
      load_data  = 32'h0;
      misaligned = 1'b0;
      case (instr_id)
         INSTR_LB:  load_data = {{24{w_byte[7]}}, w_byte};
         INSTR_LBU: load_data = {24'h0, w_byte};
         INSTR_LH: begin
            load_data  = {{16{w_half[15]}}, w_half};
            misaligned = addr_lo[0];
         end
         INSTR_LHU: begin
            load_data  = {16'h0, w_half};
            misaligned = addr_lo[0];
         end
         INSTR_LW: begin
            load_data  = rdata;
            misaligned = (addr_lo != 2'b00);
         end
         INSTR_SB: begin
            wstrb = 4'b0001 << addr_lo;
            wdata = {4{rs2[7:0]}};
         end
         INSTR_SH: begin
            wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{rs2[15:0]}};
            misaligned = addr_lo[0];
         end
         INSTR_SW: begin
            wstrb      = 4'b1111;
            wdata      = rs2;
            misaligned = (addr_lo != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues aligned req/ack data-memory requests,
// stalls upstream while busy and registers the result for writeback.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [5:0]  instr_id_in,
   input  logic        rd_valid_in,
   input  logic [4:0]  rd_addr_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] store_data_in,
   output logic        stall_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        rd_valid_out,
   output logic [4:0]  rd_addr_out,
   output logic [31:0] rd_value_out,
   output logic [31:0] load_data_out,
   output logic [5:0]  instr_id_out,
   output logic        misaligned_out,
   output logic        bus_error_out
);

   mem_state_e  r_state, w_next_state;
   logic [31:0] r_tcount;
   logic [31:0] r_addr;
   logic        r_we;
   logic [3:0]  r_wstrb;
   logic [31:0] r_wdata;
   logic        r_rd_valid;
   logic [4:0]  r_rd_addr;
   logic [5:0]  r_instr_id;

   logic        r_rd_valid_out;
   logic [4:0]  r_rd_addr_out;
   logic [31:0] r_rd_value_out;
   logic [31:0] r_load_data_out;
   logic [5:0]  r_instr_id_out;
   logic        r_misaligned_out;
   logic        r_bus_error_out;

   logic        w_busy;
   logic        w_is_mem;
   logic        w_issue;
   logic        w_timeout;
   logic [5:0]  w_align_id;
   logic [1:0]  w_align_addr;
   logic [3:0]  w_wstrb;
   logic [31:0] w_wdata;
   logic [31:0] w_load_data;
   logic        w_misaligned;

   // One aligner serves both paths: live op while idle, captured op while busy.
   assign w_busy       = (r_state == MEM_BUSY);
   assign w_is_mem     = is_mem(instr_id_in);
   assign w_align_id   = w_busy ? r_instr_id : instr_id_in;
   assign w_align_addr = w_busy ? r_addr[1:0] : alu_result_in[1:0];
   assign w_issue      = !w_busy && valid_in && w_is_mem && !w_misaligned;
   assign w_timeout    = w_busy && !dmem_ack && (TIMEOUT_CYCLES != 0) &&
                         (r_tcount == 32'(TIMEOUT_CYCLES - 1));

   mem_align u_align (
      .instr_id   (w_align_id),
      .addr_lo    (w_align_addr),
      .rs2        (store_data_in),
      .rdata      (dmem_rdata),
      .wstrb      (w_wstrb),
      .wdata      (w_wdata),
      .load_data  (w_load_data),
      .misaligned (w_misaligned)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= MEM_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         MEM_IDLE: if (w_issue) w_next_state = MEM_BUSY;
         MEM_BUSY: if (dmem_ack || w_timeout) w_next_state = MEM_IDLE;
         default:  w_next_state = MEM_IDLE;
      endcase
   end

   // Stall releases in the completing cycle so upstream advances exactly once.
   always_comb begin
      stall_out = 1'b0;
      dmem_req  = 1'b0;
      case (r_state)
         MEM_IDLE: stall_out = w_issue;
         MEM_BUSY: begin
            stall_out = !dmem_ack && !w_timeout;
            dmem_req  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || !w_busy) r_tcount <= 32'h0;
      else                r_tcount <= r_tcount + 32'h1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr     <= 32'h0;
         r_we       <= 1'b0;
         r_wstrb    <= 4'h0;
         r_wdata    <= 32'h0;
         r_rd_valid <= 1'b0;
         r_rd_addr  <= 5'h0;
         r_instr_id <= 6'h0;
      end else if (w_issue) begin
         r_addr     <= alu_result_in;
         r_we       <= is_store(instr_id_in);
         r_wstrb    <= w_wstrb;
         r_wdata    <= w_wdata;
         r_rd_valid <= rd_valid_in;
         r_rd_addr  <= rd_addr_in;
         r_instr_id <= instr_id_in;
      end
   end

   assign dmem_addr  = {r_addr[31:2], 2'b00};
   assign dmem_we    = r_we;
   assign dmem_wstrb = r_wstrb;
   assign dmem_wdata = r_wdata;

   always_ff @(posedge clk) begin
      r_rd_valid_out   <= 1'b0;
      r_rd_addr_out    <= 5'h0;
      r_rd_value_out   <= 32'h0;
      r_load_data_out  <= 32'h0;
      r_instr_id_out   <= 6'h0;
      r_misaligned_out <= 1'b0;
      r_bus_error_out  <= 1'b0;
      if (!rst) begin
         if (!w_busy && valid_in && !w_is_mem) begin
            r_rd_valid_out <= rd_valid_in;
            r_rd_addr_out  <= rd_addr_in;
            r_rd_value_out <= alu_result_in;
            r_instr_id_out <= instr_id_in;
         end else if (!w_busy && valid_in && w_misaligned) begin
            r_rd_addr_out    <= rd_addr_in;
            r_instr_id_out   <= instr_id_in;
            r_misaligned_out <= 1'b1;
         end else if (w_busy && dmem_ack) begin
            r_rd_addr_out  <= r_rd_addr;
            r_instr_id_out <= r_instr_id;
            if (is_load(r_instr_id)) begin
               r_rd_valid_out  <= r_rd_valid;
               r_rd_value_out  <= w_load_data;
               r_load_data_out <= w_load_data;
            end else begin
               r_rd_value_out <= r_addr;
            end
         end else if (w_timeout) begin
            r_rd_addr_out   <= r_rd_addr;
            r_instr_id_out  <= r_instr_id;
            r_bus_error_out <= 1'b1;
         end
      end
   end

   assign rd_valid_out   = r_rd_valid_out;
   assign rd_addr_out    = r_rd_addr_out;
   assign rd_value_out   = r_rd_value_out;
   assign load_data_out  = r_load_data_out;
   assign instr_id_out   = r_instr_id_out;
   assign misaligned_out = r_misaligned_out;
   assign bus_error_out  = r_bus_error_out;

endmodule
